// File: rtl/uart_cmd_sender_if.sv
// rtl/uart_cmd_sender_if.sv - request/operand inputs and serial/status outputs of uart_cmd_sender
interface uart_cmd_sender_if #(
    parameter int N_BITS    = 8,
    parameter int N_BITS_OP = 6
);
    logic                 i_start;
    logic [N_BITS-1:0]    i_data_a;
    logic [N_BITS-1:0]    i_data_b;
    logic [N_BITS_OP-1:0] i_op;
    logic                 o_tx;
    logic                 o_busy;
    logic                 o_done;

    modport master (
        output i_start, i_data_a, i_data_b, i_op,
        input  o_tx, o_busy, o_done
    );

    modport slave (
        input  i_start, i_data_a, i_data_b, i_op,
        output o_tx, o_busy, o_done
    );
endinterface

// File: rtl/uart_cmd_sender.sv
// rtl/uart_cmd_sender.sv - serializes operand A, operand B and opcode as three 8N1 frames
module uart_cmd_sender #(
    parameter int N_BITS    = 8,
    parameter int N_BITS_OP = 6,
    parameter int LIMITE    = 163,
    parameter int NB_CONTA  = 8,
    parameter int N_TICKS   = 16,
    parameter int GAP_BITS  = 2
) (
    input  logic              i_clock,
    input  logic              i_reset,
    uart_cmd_sender_if.slave  bus
);
    localparam int TW   = (N_TICKS > 1) ? $clog2(N_TICKS) : 1;
    localparam int BMAX = (N_BITS > GAP_BITS) ? N_BITS : GAP_BITS;
    localparam int BW   = $clog2(BMAX + 1);

    localparam logic [NB_CONTA-1:0] PRESC_LAST = NB_CONTA'(LIMITE - 1);
    localparam logic [TW-1:0]       TICK_LAST  = TW'(N_TICKS - 1);
    localparam logic [BW-1:0]       DATA_LAST  = BW'(N_BITS - 1);
    localparam logic [BW-1:0]       GAP_LAST   = BW'(GAP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_GAP} state_t;

    state_t               state, state_n;
    logic [NB_CONTA-1:0]  presc, presc_n;
    logic [TW-1:0]        tick, tick_n;
    logic [BW-1:0]        bit_idx, bit_idx_n;
    logic [1:0]           frm, frm_n;
    logic [N_BITS-1:0]    shift, shift_n;
    logic [N_BITS-1:0]    b_q, b_q_n;
    logic [N_BITS_OP-1:0] op_q, op_q_n;
    logic                 tx_q, tx_n;
    logic                 busy_q, busy_n;
    logic                 done_q, done_n;
    logic                 bit_end;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state   <= S_IDLE;
            presc   <= '0;
            tick    <= '0;
            bit_idx <= '0;
            frm     <= '0;
            shift   <= '0;
            b_q     <= '0;
            op_q    <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            presc   <= presc_n;
            tick    <= tick_n;
            bit_idx <= bit_idx_n;
            frm     <= frm_n;
            shift   <= shift_n;
            b_q     <= b_q_n;
            op_q    <= op_q_n;
            tx_q    <= tx_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    // tx is computed one cycle ahead so the line changes exactly on the bit boundary edge
    always_comb begin
        state_n   = state;
        presc_n   = presc;
        tick_n    = tick;
        bit_idx_n = bit_idx;
        frm_n     = frm;
        shift_n   = shift;
        b_q_n     = b_q;
        op_q_n    = op_q;
        tx_n      = tx_q;
        busy_n    = busy_q;
        done_n    = 1'b0;
        bit_end   = (presc == PRESC_LAST) && (tick == TICK_LAST);

        if (state != S_IDLE) begin
            presc_n = (presc == PRESC_LAST) ? '0 : presc + 1'b1;
            if (presc == PRESC_LAST)
                tick_n = (tick == TICK_LAST) ? '0 : tick + 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (bus.i_start) begin
                    shift_n   = bus.i_data_a;
                    b_q_n     = bus.i_data_b;
                    op_q_n    = bus.i_op;
                    frm_n     = '0;
                    presc_n   = '0;
                    tick_n    = '0;
                    bit_idx_n = '0;
                    tx_n      = 1'b0;
                    busy_n    = 1'b1;
                    state_n   = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    tx_n      = shift[0];
                    bit_idx_n = '0;
                    state_n   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx == DATA_LAST) begin
                        tx_n      = 1'b1;
                        bit_idx_n = '0;
                        state_n   = S_STOP;
                    end else begin
                        shift_n   = shift >> 1;
                        tx_n      = shift[1];
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    tx_n      = 1'b1;
                    bit_idx_n = '0;
                    state_n   = S_GAP;
                end
            end
            S_GAP: begin
                if (bit_end) begin
                    if (bit_idx != GAP_LAST) begin
                        bit_idx_n = bit_idx + 1'b1;
                    end else if (frm == 2'd2) begin
                        bit_idx_n = '0;
                        busy_n    = 1'b0;
                        done_n    = 1'b1;
                        state_n   = S_IDLE;
                    end else begin
                        bit_idx_n = '0;
                        frm_n     = frm + 2'd1;
                        shift_n   = (frm == 2'd0) ? b_q : N_BITS'(op_q);
                        tx_n      = 1'b0;
                        state_n   = S_START;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.o_tx   = tx_q;
    assign bus.o_busy = busy_q;
    assign bus.o_done = done_q;
endmodule

// File: tb/tb_uart_cmd_sender.sv
// tb/tb_uart_cmd_sender.sv - randomized self-checking bench for uart_cmd_sender
module tb_uart_cmd_sender;
    localparam int LIMITE   = 4;
    localparam int N_TICKS  = 4;
    localparam int GAP_BITS = 2;
    localparam int BIT      = LIMITE * N_TICKS;
    localparam int FB       = 1 + 8 + 1 + GAP_BITS;
    localparam int FRAME    = FB * BIT;
    localparam int TXN      = 3 * FRAME;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    uart_cmd_sender_if #(.N_BITS(8), .N_BITS_OP(6)) bus ();

    uart_cmd_sender #(
        .N_BITS(8), .N_BITS_OP(6), .LIMITE(LIMITE), .NB_CONTA(8),
        .N_TICKS(N_TICKS), .GAP_BITS(GAP_BITS)
    ) dut (
        .i_clock(clk),
        .i_reset(rst_n),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Expected line level during bit number bitn of a transaction: start, data LSB first, stop, gap.
    function automatic logic exp_level(input logic [23:0] frs, input int bitn);
        int f = bitn / FB;
        int p = bitn % FB;
        if (p == 0) return 1'b0;
        if (p <= 8) return frs[f*8 + p - 1];
        return 1'b1;
    endfunction

    task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        bus.i_data_a = a;
        bus.i_data_b = b;
        bus.i_op     = op;
        bus.i_start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_start  = 1'b0;
    endtask

    // Called at the negedge of cycle 0 (first start-bit cycle); returns at the negedge of the done cycle.
    task automatic monitor(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic [5:0] op, input bit poke, input bit chain,
                           input logic [7:0] na);
        logic [23:0] frs;
        logic        mid [3*FB];
        logic [7:0]  dec;
        logic        gap_ok;
        int tx_err = 0, busy_err = 0, done_err = 0;
        frs = {2'b00, op, b, a};
        for (int k = 0; k <= TXN; k++) begin
            if (k < TXN) begin
                if (bus.o_tx !== exp_level(frs, k / BIT)) tx_err++;
                if (bus.o_busy !== 1'b1) busy_err++;
                if (bus.o_done !== 1'b0) done_err++;
                if (k % BIT == BIT / 2) mid[k / BIT] = bus.o_tx;
            end else begin
                if (bus.o_tx !== 1'b1) tx_err++;
                if (bus.o_busy !== 1'b0) busy_err++;
                if (bus.o_done !== 1'b1) done_err++;
            end
            if (poke && k == FRAME + 3*BIT) begin
                bus.i_start  = 1'b1;
                bus.i_data_a = 8'hFF;
            end
            if (poke && k == FRAME + 3*BIT + 1) bus.i_start = 1'b0;
            if (chain && k == TXN) begin
                bus.i_data_a = na;
                bus.i_start  = 1'b1;
            end
            if (k < TXN) @(negedge clk);
        end
        check({name, " tx_cycle_errs"}, tx_err, 0);
        check({name, " busy_cycle_errs"}, busy_err, 0);
        check({name, " done_cycle_errs"}, done_err, 0);
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 8; i++) dec[i] = mid[f*FB + 1 + i];
            gap_ok = 1'b1;
            for (int p = 10; p < FB; p++) gap_ok &= mid[f*FB + p];
            check($sformatf("%s f%0d start", name, f), mid[f*FB], 0);
            check($sformatf("%s f%0d data", name, f), dec, frs[f*8 +: 8]);
            check($sformatf("%s f%0d stop", name, f), mid[f*FB + 9], 1);
            check($sformatf("%s f%0d gap", name, f), gap_ok, 1);
        end
    endtask

    task automatic idle_check(input string name, input int cycles);
        int err = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (bus.o_tx !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) err++;
        end
        check({name, " idle_errs"}, err, 0);
    endtask

    initial begin
        logic [7:0] a, b;
        logic [5:0] op;
        int err;

        bus.i_start  = 1'b1;
        bus.i_data_a = 8'hA5;
        bus.i_data_b = 8'h3C;
        bus.i_op     = 6'h11;

        err = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.o_tx !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) err++;
        end
        check("reset outputs", err, 0);
        check("reset tx", bus.o_tx, 1);
        check("reset busy", bus.o_busy, 0);

        // start held high across release: accepted on the first edge after deassertion
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_start = 1'b0;
        monitor("post_reset", 8'hA5, 8'h3C, 6'h11, 1'b0, 1'b0, 8'h00);
        idle_check("post_reset", 2*BIT);

        @(negedge clk);
        launch(8'h55, 8'h57, 6'b100100);
        monitor("directed", 8'h55, 8'h57, 6'b100100, 1'b0, 1'b0, 8'h00);
        idle_check("directed", 2*BIT);

        a = 8'($urandom); b = 8'($urandom); op = 6'($urandom);
        launch(a, b, op);
        monitor("busy_poke", a, b, op, 1'b1, 1'b0, 8'h00);
        idle_check("busy_poke", 3*BIT);

        a = 8'($urandom); b = 8'($urandom); op = 6'($urandom);
        launch(a, b, op);
        monitor("chain1", a, b, op, 1'b0, 1'b1, 8'h0F);
        @(posedge clk);
        @(negedge clk);
        bus.i_start = 1'b0;
        monitor("chain2", 8'h0F, b, op, 1'b0, 1'b0, 8'h00);
        idle_check("chain2", 2*BIT);

        a = 8'($urandom); b = 8'($urandom) & 8'hF7; op = 6'($urandom);
        launch(a, b, op);
        repeat (FRAME + 4*BIT + BIT/2) @(negedge clk);
        check("midreset pre tx", bus.o_tx, 0);
        rst_n = 1'b0;
        #1;
        check("midreset async tx", bus.o_tx, 1);
        check("midreset async busy", bus.o_busy, 0);
        err = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.o_tx !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) err++;
        end
        check("midreset hold", err, 0);
        rst_n = 1'b1;
        idle_check("midreset release", 2*BIT);
        a = 8'($urandom); b = 8'($urandom); op = 6'($urandom);
        launch(a, b, op);
        monitor("after_midreset", a, b, op, 1'b0, 1'b0, 8'h00);

        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            a = 8'($urandom); b = 8'($urandom); op = 6'($urandom);
            launch(a, b, op);
            monitor($sformatf("rand%0d", t), a, b, op, 1'b0, 1'b0, 8'h00);
        end
        idle_check("final", 2*BIT);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
